wb_stage: RTL and testbench

//  Writeback stage of the RV32I pipeline; sits directly upstream of the register file.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_load_align.sv | 42 ++++
 rtl/wb_stage.sv | 139 +++++++++++++
 tb/tb_wb_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the RV32I writeback stage: result selects, load funct3 codes, FSM states.
package wb_pkg;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load extractor: picks the byte/half/word addressed by addr_lo out of an
// aligned memory word, extends it per funct3, and flags misaligned or illegal load types.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = '0;
    err_o  = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data_o = {{(XLEN-16){half_v[15]}}, half_v};
        err_o  = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o = {{(XLEN-16){1'b0}}, half_v};
        err_o  = addr_lo_i[0];
      end
      F3_LW: begin
        data_o = rdata_i;
        err_o  = (addr_lo_i != 2'b00);
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: selects ALU / load / PC+4 result, waits for load data, and drives
// the register-file write port plus bypass, load-pending hint and retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  // Handshake: an instruction transfers on a clock edge where in_valid && in_ready.
  // in_ready is low only while a load waits for its data.
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rd,
  input  logic             in_rd_en,
  input  logic [1:0]       in_sel,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             WB,
  output logic [AW-1:0]    rd_address,
  output logic [XLEN-1:0]  write_data,
  output logic             fwd_valid,
  output logic [AW-1:0]    fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             load_pending,
  output logic [AW-1:0]    pend_rd,
  output logic             misalign_err,
  output logic [CNT_W-1:0] retired_count,
  output logic [1:0]       state_dbg
);

  wb_state_t        state_q;
  logic             wb_q;
  logic [AW-1:0]    rd_addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic             pending_q;
  logic [AW-1:0]    pend_rd_q;
  logic             pend_rd_en_q;
  logic [2:0]       pend_f3_q;
  logic [1:0]       pend_lo_q;
  logic             err_q;
  logic [CNT_W-1:0] count_q;

  logic             accept;
  logic [2:0]       la_f3;
  logic [1:0]       la_lo;
  logic [XLEN-1:0]  la_data;
  logic             la_err;

  assign in_ready = (state_q != S_WAIT_MEM);
  assign accept   = in_valid && in_ready;

  // One aligner serves both uses: legality check of the incoming load (IDLE/COMMIT)
  // and data extraction for the captured load (WAIT_MEM).
  assign la_f3 = (state_q == S_WAIT_MEM) ? pend_f3_q : in_funct3;
  assign la_lo = (state_q == S_WAIT_MEM) ? pend_lo_q : in_addr_lo;

  load_align #(.XLEN(XLEN)) u_load_align (
    .funct3_i  (la_f3),
    .addr_lo_i (la_lo),
    .rdata_i   (mem_rdata),
    .data_o    (la_data),
    .err_o     (la_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wb_q         <= 1'b0;
      rd_addr_q    <= '0;
      wdata_q      <= '0;
      pending_q    <= 1'b0;
      pend_rd_q    <= '0;
      pend_rd_en_q <= 1'b0;
      pend_f3_q    <= '0;
      pend_lo_q    <= '0;
      err_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      case (state_q)
        S_WAIT_MEM: begin
          if (mem_rvalid) begin
            state_q   <= S_COMMIT;
            wb_q      <= pend_rd_en_q && (pend_rd_q != '0);
            rd_addr_q <= pend_rd_q;
            wdata_q   <= la_data;
            pending_q <= 1'b0;
            pend_rd_q <= '0;
            count_q   <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          wb_q  <= 1'b0;
          err_q <= 1'b0;
          if (!accept) begin
            state_q <= S_IDLE;
          end else if (in_sel == SEL_LOAD) begin
            if (la_err) begin
              state_q <= S_COMMIT;
              err_q   <= 1'b1;
            end else begin
              state_q      <= S_WAIT_MEM;
              pending_q    <= 1'b1;
              pend_rd_q    <= in_rd;
              pend_rd_en_q <= in_rd_en;
              pend_f3_q    <= in_funct3;
              pend_lo_q    <= in_addr_lo;
            end
          end else begin
            state_q   <= S_COMMIT;
            wb_q      <= in_rd_en && (in_rd != '0);
            rd_addr_q <= in_rd;
            wdata_q   <= (in_sel == SEL_PC4) ? in_pc4 : in_alu_result;
            count_q   <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      endcase
    end
  end

  assign WB            = wb_q;
  assign rd_address    = rd_addr_q;
  assign write_data    = wdata_q;
  assign fwd_valid     = wb_q;
  assign fwd_rd        = rd_addr_q;
  assign fwd_data      = wdata_q;
  assign load_pending  = pending_q;
  assign pend_rd       = pend_rd_q;
  assign misalign_err  = err_q;
  assign retired_count = count_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage: one task per scenario with inline expected-value checks.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [4:0]  in_rd;
  logic        in_rd_en;
  logic [1:0]  in_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc4;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        wb, wb4;
  logic [4:0]  rd_address, rd_address4;
  logic [31:0] write_data, write_data4;
  logic        fwd_valid, fwd_valid4;
  logic [4:0]  fwd_rd, fwd_rd4;
  logic [31:0] fwd_data, fwd_data4;
  logic        load_pending, load_pending4;
  logic [4:0]  pend_rd, pend_rd4;
  logic        misalign_err, misalign_err4;
  logic [31:0] retired_count;
  logic [3:0]  retired_count4;
  logic [1:0]  state_dbg, state_dbg4;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_rd_en(in_rd_en), .in_sel(in_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_pc4(in_pc4), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .WB(wb), .rd_address(rd_address), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .load_pending(load_pending), .pend_rd(pend_rd), .misalign_err(misalign_err),
    .retired_count(retired_count), .state_dbg(state_dbg)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_rd(in_rd),
    .in_rd_en(in_rd_en), .in_sel(in_sel), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result), .in_pc4(in_pc4), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .WB(wb4), .rd_address(rd_address4), .write_data(write_data4),
    .fwd_valid(fwd_valid4), .fwd_rd(fwd_rd4), .fwd_data(fwd_data4),
    .load_pending(load_pending4), .pend_rd(pend_rd4), .misalign_err(misalign_err4),
    .retired_count(retired_count4), .state_dbg(state_dbg4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_rd         = '0;
    in_rd_en      = 1'b0;
    in_sel        = SEL_ALU;
    in_funct3     = '0;
    in_addr_lo    = '0;
    in_alu_result = '0;
    in_pc4        = '0;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic rd_en,
                       input logic [2:0] f3, input logic [1:0] lo,
                       input logic [31:0] alu, input logic [31:0] pc4);
    in_valid      = 1'b1;
    in_sel        = sel;
    in_rd         = rd;
    in_rd_en      = rd_en;
    in_funct3     = f3;
    in_addr_lo    = lo;
    in_alu_result = alu;
    in_pc4        = pc4;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_cnt = 0;
    checks += 8;
    if (wb !== 1'b0) begin failures++; $display("FAIL reset_wb got=%0b exp=0", wb); end
    if (rd_address !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_address); end
    if (write_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", write_data); end
    if (load_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%0b exp=0", load_pending); end
    if (pend_rd !== 5'd0) begin failures++; $display("FAIL reset_pend_rd got=%0d exp=0", pend_rd); end
    if (misalign_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", misalign_err); end
    if (retired_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", retired_count); end
    if (in_ready !== 1'b1 || state_dbg !== S_IDLE) begin
      failures++; $display("FAIL reset_state ready=%0b state=%0d exp ready=1 state=0", in_ready, state_dbg);
    end
  endtask

  task automatic test_alu();
    drive(SEL_ALU, 5'd5, 1'b1, 3'd0, 2'd0, 32'h1234_5678, 32'h0);
    tick();
    idle_inputs();
    exp_cnt++;
    checks += 4;
    if (wb !== 1'b1 || rd_address !== 5'd5) begin
      failures++; $display("FAIL alu_wb wb=%0b rd=%0d exp wb=1 rd=5", wb, rd_address);
    end
    if (write_data !== 32'h1234_5678) begin failures++; $display("FAIL alu_data got=%h exp=12345678", write_data); end
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h1234_5678) begin
      failures++; $display("FAIL alu_fwd v=%0b rd=%0d d=%h exp 1/5/12345678", fwd_valid, fwd_rd, fwd_data);
    end
    if (retired_count !== 32'(exp_cnt)) begin failures++; $display("FAIL alu_count got=%0d exp=%0d", retired_count, exp_cnt); end
    tick();
    checks += 2;
    if (wb !== 1'b0 || state_dbg !== S_IDLE) begin
      failures++; $display("FAIL alu_after wb=%0b state=%0d exp wb=0 state=0", wb, state_dbg);
    end
    if (rd_address !== 5'd5 || write_data !== 32'h1234_5678) begin
      failures++; $display("FAIL alu_hold rd=%0d d=%h exp 5/12345678", rd_address, write_data);
    end
  endtask

  task automatic test_back_to_back();
    drive(SEL_PC4, 5'd1, 1'b1, 3'd0, 2'd0, 32'hDEAD_0000, 32'h0000_0104);
    tick();
    exp_cnt++;
    checks += 2;
    if (wb !== 1'b1 || rd_address !== 5'd1 || write_data !== 32'h104) begin
      failures++; $display("FAIL b2b_pc4 wb=%0b rd=%0d d=%h exp 1/1/104", wb, rd_address, write_data);
    end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%0b exp=1", in_ready); end
    drive(SEL_ALU, 5'd0, 1'b1, 3'd0, 2'd0, 32'h0000_0055, 32'h0);
    tick();
    idle_inputs();
    exp_cnt++;
    checks += 3;
    if (wb !== 1'b0) begin failures++; $display("FAIL b2b_rd0 wb got=%0b exp=0", wb); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready2 got=%0b exp=1", in_ready); end
    if (retired_count !== 32'(exp_cnt)) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", retired_count, exp_cnt); end
    tick();
  endtask

  task automatic test_load_lb();
    // mem_rvalid outside WAIT_MEM must do nothing
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    checks++;
    if (wb !== 1'b0 || retired_count !== 32'(exp_cnt)) begin
      failures++; $display("FAIL stray_rvalid wb=%0b count=%0d exp 0/%0d", wb, retired_count, exp_cnt);
    end
    drive(SEL_LOAD, 5'd7, 1'b1, F3_LB, 2'd3, 32'h0, 32'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || load_pending !== 1'b1 || pend_rd !== 5'd7 || wb !== 1'b0) begin
        failures++;
        $display("FAIL lb_wait%0d ready=%0b pend=%0b prd=%0d wb=%0b exp 0/1/7/0", i, in_ready, load_pending, pend_rd, wb);
      end
      if (i < 2) tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_FF7F;
    tick();
    idle_inputs();
    exp_cnt++;
    checks += 3;
    if (wb !== 1'b1 || rd_address !== 5'd7 || write_data !== 32'hFFFF_FF80) begin
      failures++; $display("FAIL lb_commit wb=%0b rd=%0d d=%h exp 1/7/ffffff80", wb, rd_address, write_data);
    end
    if (load_pending !== 1'b0 || pend_rd !== 5'd0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL lb_clear pend=%0b prd=%0d ready=%0b exp 0/0/1", load_pending, pend_rd, in_ready);
    end
    if (retired_count !== 32'(exp_cnt)) begin failures++; $display("FAIL lb_count got=%0d exp=%0d", retired_count, exp_cnt); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [6] = '{F3_LHU, F3_LB, F3_LBU, F3_LH, F3_LW, F3_LB};
    logic [1:0]  lo  [6] = '{2'd2, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] rdt [6] = '{32'hBEEF_0000, 32'h80FF_FF7F, 32'h80FF_FF7F, 32'h80FF_FF7F,
                             32'hCAFE_BABE, 32'h80FF_FF7F};
    logic [31:0] exp [6] = '{32'h0000_BEEF, 32'h0000_007F, 32'h0000_0080, 32'hFFFF_80FF,
                             32'hCAFE_BABE, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      drive(SEL_LOAD, 5'(9 + i), 1'b1, f3[i], lo[i], 32'h0, 32'h0);
      tick();
      idle_inputs();
      mem_rvalid = 1'b1;
      mem_rdata  = rdt[i];
      tick();
      idle_inputs();
      exp_cnt++;
      checks += 2;
      if (wb !== 1'b1 || rd_address !== 5'(9 + i) || write_data !== exp[i]) begin
        failures++;
        $display("FAIL load%0d wb=%0b rd=%0d d=%h exp 1/%0d/%h", i, wb, rd_address, write_data, 9 + i, exp[i]);
      end
      if (retired_count !== 32'(exp_cnt)) begin failures++; $display("FAIL load%0d_count got=%0d exp=%0d", i, retired_count, exp_cnt); end
    end
    tick();
  endtask

  task automatic test_misalign();
    logic [2:0] f3 [4] = '{F3_LW, F3_LH, 3'b011, 3'b110};
    logic [1:0] lo [4] = '{2'd1, 2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 4; i++) begin
      drive(SEL_LOAD, 5'd3, 1'b1, f3[i], lo[i], 32'h0, 32'h0);
      tick();
      idle_inputs();
      checks += 2;
      if (misalign_err !== 1'b1 || wb !== 1'b0 || load_pending !== 1'b0) begin
        failures++;
        $display("FAIL err%0d err=%0b wb=%0b pend=%0b exp 1/0/0", i, misalign_err, wb, load_pending);
      end
      if (retired_count !== 32'(exp_cnt) || in_ready !== 1'b1) begin
        failures++; $display("FAIL err%0d_count count=%0d ready=%0b exp %0d/1", i, retired_count, in_ready, exp_cnt);
      end
      tick();
      checks++;
      if (misalign_err !== 1'b0) begin failures++; $display("FAIL err%0d_pulse got=%0b exp=0", i, misalign_err); end
    end
  endtask

  task automatic test_reset_wait();
    drive(SEL_LOAD, 5'd4, 1'b1, F3_LW, 2'd0, 32'h0, 32'h0);
    tick();
    idle_inputs();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_1111;
    tick();
    rst = 1'b0;
    mem_rdata = 32'h2222_2222;
    tick();
    idle_inputs();
    exp_cnt = 0;
    checks += 3;
    if (wb !== 1'b0 || wb4 !== 1'b0) begin failures++; $display("FAIL rstw_wb got=%0b/%0b exp=0", wb, wb4); end
    if (state_dbg !== S_IDLE || load_pending !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rstw_state st=%0d pend=%0b ready=%0b exp 0/0/1", state_dbg, load_pending, in_ready);
    end
    if (retired_count !== 32'd0 || retired_count4 !== 4'd0) begin
      failures++; $display("FAIL rstw_count got=%0d/%0d exp=0", retired_count, retired_count4);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      drive(SEL_ALU, 5'd2, 1'b1, 3'd0, 2'd0, 32'(i), 32'h0);
      tick();
      exp_cnt++;
      if (i == 14) begin
        checks++;
        if (retired_count4 !== 4'd15) begin failures++; $display("FAIL wrap15 got=%0d exp=15", retired_count4); end
      end
    end
    idle_inputs();
    checks += 2;
    if (retired_count4 !== 4'd0) begin failures++; $display("FAIL wrap16 got=%0d exp=0", retired_count4); end
    if (retired_count !== 32'(exp_cnt) || write_data !== 32'd15) begin
      failures++; $display("FAIL wrap_wide count=%0d d=%h exp %0d/f", retired_count, write_data, exp_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load_lb();
    test_loads();
    test_misalign();
    test_reset_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
